latency_memory_responder: RTL and testbench

- Memory-side end of the core's fetch/load/store handshake. The core issues requests; this block answers with `ready`, `valid`, an echoed address and read data. The hazard logic consumes these as `fetch_ready`/`fetch_valid`/`fetch_address_in` or `memory_ready`/`memory_valid`/`memory_address_in`.
- Holds an internal byte-enabled word store.
- Inserts a programmable fixed latency so the bench and SoC can exercise the core's stall paths.
- One request outstanding at a time.

---
 rtl/latency_memory_responder_pkg.sv | 24 ++
 rtl/latency_memory_responder_byte_enable_sram.sv | 33 +++
 rtl/latency_memory_responder.sv | 137 +++++++++++++
 tb/tb_latency_memory_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/latency_memory_responder_pkg.sv
// Shared definitions for the latency memory responder: FSM state encoding
// and the log2 helper used to size address fields.
package latency_memory_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic int unsigned log2_f(input int unsigned value);
      int unsigned result;
      result = 32'd0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) begin
            result = i + 32'd1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/latency_memory_responder_byte_enable_sram.sv
// Single-port word array: synchronous per-byte write, combinational read.
// Contents are deliberately not reset.
module byte_enable_sram #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_BYTES  = DATA_WIDTH / 8,
   parameter int INDEX_BITS = 8
) (
   input  logic                  clock,
   input  logic                  write_en_i,
   input  logic [INDEX_BITS-1:0] index_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [NUM_BYTES-1:0]  byte_en_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam int BYTE_W = DATA_WIDTH / NUM_BYTES;

   logic [DATA_WIDTH-1:0] mem_q [2**INDEX_BITS];

   // Byte-lane write port
   always_ff @(posedge clock) begin
      if (write_en_i) begin
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (byte_en_i[b]) begin
               mem_q[index_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   assign rdata_o = mem_q[index_i];

endmodule

// File: rtl/latency_memory_responder.sv
// Memory-side responder for the core handshake: accepts one request at a
// time, commits writes immediately and answers after a fixed LATENCY.
module latency_memory_responder
   import latency_memory_responder_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 20,
   parameter int NUM_BYTES    = DATA_WIDTH / 8,
   parameter int INDEX_BITS   = 8,
   parameter int LATENCY      = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    read,
   input  logic                    write,
   input  logic [ADDRESS_BITS-1:0] address,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic [NUM_BYTES-1:0]    byte_en,
   output logic                    ready,
   output logic                    valid,
   output logic [ADDRESS_BITS-1:0] out_address,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic [7:0]              busy_count
);

   localparam int unsigned OFFSET_BITS = log2_f(NUM_BYTES);
   localparam int          BYTE_W      = DATA_WIDTH / NUM_BYTES;
   localparam logic [7:0]  LAT_M1      = 8'(LATENCY - 1);

   if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
      $error("latency_memory_responder: LATENCY must be within 1..255");
   end

   state_e                  state_q, state_d;
   logic [7:0]              count_q, count_d;
   logic                    ready_q, valid_q;
   logic [ADDRESS_BITS-1:0] addr_q;
   logic [DATA_WIDTH-1:0]   data_q;

   logic                    accept_s;
   logic [INDEX_BITS-1:0]   index_s;
   logic [DATA_WIDTH-1:0]   rdata_s;
   logic [DATA_WIDTH-1:0]   merged_s;
   logic [DATA_WIDTH-1:0]   resp_word_s;

   assign accept_s    = ready_q & (read | write);
   assign index_s     = address[OFFSET_BITS +: INDEX_BITS];
   assign resp_word_s = write ? merged_s : rdata_s;

   byte_enable_sram #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_BYTES  (NUM_BYTES),
      .INDEX_BITS (INDEX_BITS)
   ) u_sram (
      .clock      (clock),
      .write_en_i (accept_s & write),
      .index_i    (index_s),
      .wdata_i    (in_data),
      .byte_en_i  (byte_en),
      .rdata_o    (rdata_s)
   );

   // Post-write word as the store will hold it after this edge
   always_comb begin
      merged_s = rdata_s;
      for (int b = 0; b < NUM_BYTES; b++) begin
         if (byte_en[b]) begin
            merged_s[b*BYTE_W +: BYTE_W] = in_data[b*BYTE_W +: BYTE_W];
         end else begin
            merged_s[b*BYTE_W +: BYTE_W] = rdata_s[b*BYTE_W +: BYTE_W];
         end
      end
   end

   // Next state and latency countdown
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         IDLE, RESP: begin
            if (accept_s) begin
               if (LATENCY == 1) begin
                  state_d = RESP;
                  count_d = 8'd0;
               end else begin
                  state_d = BUSY;
                  count_d = LAT_M1;
               end
            end else begin
               state_d = IDLE;
               count_d = 8'd0;
            end
         end
         BUSY: begin
            if (count_q <= 8'd1) begin
               state_d = RESP;
               count_d = 8'd0;
            end else begin
               state_d = BUSY;
               count_d = count_q - 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = 8'd0;
         end
      endcase
   end

   // State and registered handshake/response outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         count_q <= 8'd0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ready_q <= (state_d != BUSY);
         valid_q <= (state_d == RESP);
         if (accept_s) begin
            addr_q <= address;
            data_q <= resp_word_s;
         end
      end
   end

   assign ready       = ready_q;
   assign valid       = valid_q;
   assign out_address = addr_q;
   assign out_data    = data_q;
   assign busy_count  = count_q;

endmodule

// File: tb/tb_latency_memory_responder.sv
// Self-checking bench: three responders (LATENCY 1, 2, 4) driven by directed
// and random requests, checked against a word-array model with fixed latency.
module tb_latency_memory_responder;

   localparam int N = 3;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        rd_s    [N];
   logic        wr_s    [N];
   logic [19:0] addr_s  [N];
   logic [31:0] wdata_s [N];
   logic [3:0]  be_s    [N];
   logic        ready_s [N];
   logic        valid_s [N];
   logic [19:0] oaddr_s [N];
   logic [31:0] odata_s [N];
   logic [7:0]  bcnt_s  [N];

   logic [31:0] mem_m [N][256];
   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < N; g++) begin : g_dut
      latency_memory_responder #(
         .LATENCY ((g == 0) ? 1 : ((g == 1) ? 2 : 4))
      ) u_dut (
         .clock       (clock),
         .reset       (reset_n),
         .read        (rd_s[g]),
         .write       (wr_s[g]),
         .address     (addr_s[g]),
         .in_data     (wdata_s[g]),
         .byte_en     (be_s[g]),
         .ready       (ready_s[g]),
         .valid       (valid_s[g]),
         .out_address (oaddr_s[g]),
         .out_data    (odata_s[g]),
         .busy_count  (bcnt_s[g])
      );
   end

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
   endfunction

   task automatic check(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s dut%0d t=%0t observed=%h expected=%h", tag, i, $time, obs, exp);
   endtask

   // Issue one request at the current negedge and follow it to its response.
   task automatic do_req(input int i, input bit r, input bit w, input logic [19:0] a,
                         input logic [31:0] d, input logic [3:0] be, input bit junk);
      int          lat;
      int          waited;
      logic [7:0]  idx;
      logic [31:0] exp;
      lat = lat_of(i);
      rd_s[i] = r; wr_s[i] = w; addr_s[i] = a; wdata_s[i] = d; be_s[i] = be;
      waited = 0;
      while (ready_s[i] !== 1'b1 && waited < 20) begin
         @(negedge clock);
         waited++;
      end
      check("accept_ready", i, ready_s[i], 1);
      idx = a[9:2];
      exp = mem_m[i][idx];
      if (w) begin
         for (int b = 0; b < 4; b++) if (be[b]) exp[b*8 +: 8] = d[b*8 +: 8];
         mem_m[i][idx] = exp;
      end
      @(posedge clock);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clock);
         if (k == lat) begin
            rd_s[i] = 1'b0; wr_s[i] = 1'b0;
            check("resp_valid", i, valid_s[i], 1);
            check("resp_ready", i, ready_s[i], 1);
            check("resp_addr",  i, oaddr_s[i], a);
            check("resp_data",  i, odata_s[i], exp);
            check("resp_count", i, bcnt_s[i], 0);
         end else begin
            if (k == 1 && junk) begin
               rd_s[i] = 1'b0; wr_s[i] = 1'b1;
               addr_s[i] = a ^ 20'h00004; wdata_s[i] = ~d; be_s[i] = 4'hF;
            end else if (k == 1) begin
               rd_s[i] = 1'b0; wr_s[i] = 1'b0;
            end
            check("busy_valid", i, valid_s[i], 0);
            check("busy_ready", i, ready_s[i], 0);
            check("busy_count", i, bcnt_s[i], lat - k);
         end
      end
   endtask

   task automatic idle(input int i, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         check("idle_valid", i, valid_s[i], 0);
         check("idle_ready", i, ready_s[i], 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [19:0] a;
      logic [31:0] d;
      int          op;
      reset_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = 20'h0; wdata_s[i] = 32'h0; be_s[i] = 4'h0;
      end
      repeat (2) begin
         @(negedge clock);
         for (int i = 0; i < N; i++) begin
            check("rst_ready", i, ready_s[i], 0);
            check("rst_valid", i, valid_s[i], 0);
            check("rst_addr",  i, oaddr_s[i], 0);
            check("rst_data",  i, odata_s[i], 0);
            check("rst_count", i, bcnt_s[i], 0);
         end
      end
      reset_n = 1'b1;
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
         check("rel_ready", i, ready_s[i], 1);
         check("rel_valid", i, valid_s[i], 0);
      end

      // LATENCY=2: write/read in RESP, byte enables, alias, read+write
      do_req(1, 0, 1, 20'h00010, 32'hDEADBEEF, 4'hF, 0);
      do_req(1, 1, 0, 20'h00010, 32'h0, 4'h0, 0);
      do_req(1, 0, 1, 20'h00020, 32'hAABBCCDD, 4'hF, 1);
      idle(1, 1);
      do_req(1, 0, 1, 20'h00020, 32'h11223344, 4'b0101, 0);
      check("be_merge_model", 1, mem_m[1][8'h08], 32'hAA22CC44);
      do_req(1, 1, 0, 20'h00020, 32'h0, 4'h0, 0);
      do_req(1, 0, 1, 20'h00400, 32'h5A5A5A5A, 4'hF, 0);
      do_req(1, 1, 0, 20'h00000, 32'h0, 4'h0, 0);
      do_req(1, 1, 1, 20'h00044, 32'hCAFEF00D, 4'hF, 0);
      do_req(1, 1, 0, 20'h00044, 32'h0, 4'h0, 0);
      idle(1, 2);

      // LATENCY=1: back-to-back reads held continuously
      for (int j = 0; j < 3; j++) do_req(0, 0, 1, 20'(j * 4), 32'h0BAD0000 + 32'(j), 4'hF, 0);
      idle(0, 1);
      for (int j = 0; j < 3; j++) do_req(0, 1, 0, 20'(j * 4), 32'h0, 4'h0, 0);
      idle(0, 1);

      // LATENCY=4: reset one cycle after an accepted write
      rd_s[2] = 1'b0; wr_s[2] = 1'b1; addr_s[2] = 20'h00030; wdata_s[2] = 32'h12345678; be_s[2] = 4'hF;
      check("pre_rst_ready", 2, ready_s[2], 1);
      mem_m[2][8'h0C] = 32'h12345678;
      @(posedge clock);
      @(negedge clock);
      wr_s[2] = 1'b0;
      reset_n = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         check("midrst_valid", 2, valid_s[2], 0);
         check("midrst_ready", 2, ready_s[2], 0);
      end
      reset_n = 1'b1;
      @(negedge clock);
      check("post_rst_valid", 2, valid_s[2], 0);
      do_req(2, 1, 0, 20'h00030, 32'h0, 4'h0, 0);

      // Random traffic against the word model, aliasing upper/offset bits
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < 8; j++) begin
            a = {10'($urandom), 8'(j + 64), 2'($urandom)};
            do_req(i, 0, 1, a, $urandom, 4'hF, 1'($urandom));
         end
         for (int n = 0; n < 25; n++) begin
            a  = {10'($urandom), 8'($urandom_range(64, 71)), 2'($urandom)};
            d  = $urandom;
            op = $urandom_range(0, 2);
            do_req(i, (op != 1), (op != 0), a, d, 4'($urandom), 1'($urandom));
            idle(i, $urandom_range(0, 2));
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
